// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encoding and the conditional two's-complement helper used
// for operand magnitudes and result sign correction.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // The helper works on a fixed container wide enough for a 2*WIDTH product
  // with WIDTH up to MAX_W; callers zero-extend in and truncate out, which is
  // exact because the low bits of a negation never depend on higher bits.
  localparam int MAX_W = 64;
  localparam int NEG_W = 2 * MAX_W;

  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] val,
                                                input logic             en);
    return en ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference only
// when it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, dvd_bit_i};
  assign diff    = shifted - {1'b0, dvsr_i};
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine owning the HI/LO pair.
// Optional build macro MULDIV_FAST_MUL_EN: MULT completes in a single pass
// through a combinational multiplier (DONE one cycle after accept, busy never
// asserted); DIV stays iterative. Supports WIDTH from 4 up to muldiv_pkg::MAX_W.
//
// state   | meaning
// ST_IDLE | waiting for start; MTHI/MTLO writes honoured here
// ST_MUL  | shift-add multiply, one multiplier bit per cycle
// ST_DIV  | restoring divide, one quotient bit per cycle
// ST_DONE | hi/lo hold the new result; done pulse
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // MUL: {partial product, remaining multiplier bits}
  // DIV: {partial remainder, remaining dividend bits / quotient bits}
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             bzero_q, bzero_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [PW-1:0]    div_next;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign sign_a = is_signed & a[WIDTH-1];
  assign sign_b = is_signed & b[WIDTH-1];
  assign abs_a  = WIDTH'(cond_neg(NEG_W'(a), sign_a));
  assign abs_b  = WIDTH'(cond_neg(NEG_W'(b), sign_b));
  assign accept = (state_q == ST_IDLE) && start && !cancel &&
                  ((op == OP_MULT) || (op == OP_DIV));
  assign last   = (cnt_q == CNT_W'(1));

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (prod_q[PW-1:WIDTH]),
    .dvd_bit_i (prod_q[WIDTH-1]),
    .dvsr_i    (opnd_q),
    .rem_o     (rem_nx),
    .q_bit_o   (q_bit)
  );

  assign div_next = {rem_nx, prod_q[WIDTH-2:0], q_bit};
  assign quo_res  = WIDTH'(cond_neg(NEG_W'(div_next[WIDTH-1:0]), neg_res_q));
  assign rem_res  = WIDTH'(cond_neg(NEG_W'(div_next[PW-1:WIDTH]), neg_rem_q));

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] fast_prod;
  assign fast_prod = PW'(cond_neg(NEG_W'(PW'(abs_a) * PW'(abs_b)), sign_a ^ sign_b));
`else
  logic [WIDTH:0] mul_sum;
  logic [PW-1:0]  mul_next;
  logic [PW-1:0]  mul_res;
  assign mul_sum  = {1'b0, prod_q[PW-1:WIDTH]} +
                    (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_res  = PW'(cond_neg(NEG_W'(mul_next), neg_res_q));
`endif

  // Next-state, datapath iteration and HI/LO commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    araw_d    = araw_q;
    bzero_d   = bzero_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d     = CNT_W'(WIDTH);
          araw_d    = a;
          bzero_d   = (b == '0);
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = 1'b0;
          if (op == OP_DIV) begin
            prod_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d  = abs_b;
            state_d = ST_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            hi_d    = fast_prod[PW-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            state_d = ST_DONE;
`else
            prod_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d  = abs_a;
            state_d = ST_MUL;
`endif
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          div0_d  = 1'b0;
        end else begin
`ifndef MULDIV_FAST_MUL_EN
          prod_d = mul_next;
          cnt_d  = cnt_q - CNT_W'(1);
          if (last) begin
            hi_d    = mul_res[PW-1:WIDTH];
            lo_d    = mul_res[WIDTH-1:0];
            state_d = ST_DONE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          div0_d  = 1'b0;
        end else begin
          prod_d = div_next;
          cnt_d  = cnt_q - CNT_W'(1);
          if (last) begin
            if (bzero_q) begin
              lo_d   = '1;
              hi_d   = araw_q;
              div0_d = 1'b1;
            end else begin
              lo_d = quo_res;
              hi_d = rem_res;
            end
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      araw_q    <= '0;
      bzero_q   <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      araw_q    <= araw_d;
      bzero_q   <= bzero_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign done = (state_q == ST_DONE);
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed corner cases plus
// randomized MULT/DIV traffic against an arithmetic reference model, with a
// scoreboard drained by a monitor on every done pulse.
module tb_muldiv_hilo_unit;

  localparam int W = 32;
  localparam logic [1:0] T_MULT = 2'b00;
  localparam logic [1:0] T_DIV  = 2'b01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          is_signed = 1'b0;
  logic          cancel = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, done, div0;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t sb_q[$];

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .cancel    (cancel),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic exp_t model(input logic [1:0] o, input logic s,
                                 input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    longint          sp, sq, sr;
    longint unsigned up, uq, ur;
    e.div0 = 1'b0;
    if (o == T_MULT) begin
      if (s) begin
        sp = longint'($signed(av)) * longint'($signed(bv));
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end else begin
        up = 64'(av) * 64'(bv);
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
    end else if (bv == '0) begin
      e.lo   = '1;
      e.hi   = av;
      e.div0 = 1'b1;
    end else if (s) begin
      sq = longint'($signed(av)) / longint'($signed(bv));
      sr = longint'($signed(av)) % longint'($signed(bv));
      e.lo = sq[31:0];
      e.hi = sr[31:0];
    end else begin
      uq = 64'(av) / 64'(bv);
      ur = 64'(av) % 64'(bv);
      e.lo = uq[31:0];
      e.hi = ur[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        check("done_without_request", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        check("result_div0", 64'(div0), 64'(e.div0));
      end
    end
  end

  // Issue one op, measure busy length and done latency; optionally hold start
  // (and scramble operands) through busy and DONE to show they are ignored.
  task automatic do_op(input logic [1:0] o, input logic s,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    int nb, lat, exp_lat, exp_busy;
    nb = 0;
    lat = 0;
    exp_lat = W + 1;
    exp_busy = W;
`ifdef MULDIV_FAST_MUL_EN
    if (o == T_MULT) begin
      exp_lat = 1;
      exp_busy = 0;
    end
`endif
    sb_q.push_back(model(o, s, av, bv));
    op = o;
    is_signed = s;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("div0_clear_after_accept", 64'(div0), 64'd0);
    for (int n = 1; n <= W + 4; n++) begin
      if (busy) nb++;
      if (done) begin
        lat = n;
        break;
      end
      if (hold) begin
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    check("done_latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(nb), 64'(exp_busy));
    @(posedge clk); #1;
    if (hold) begin
      start = 1'b0;
      check("start_in_done_ignored", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    logic         rs;
    int           sel;

    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div0", 64'(div0), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(T_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op(T_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    do_op(T_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(T_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(T_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(T_DIV,  1'b0, 32'h0000_1234, 32'd0, 1'b0);
    check("div0_sticky", 64'(div0), 64'd1);
    do_op(T_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Direct writes: both in one cycle, then separately.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111;
    @(posedge clk); #1;
    check("mthi_mtlo_same_cycle_hi", 64'(hi), 64'h1111);
    check("mthi_mtlo_same_cycle_lo", 64'(lo), 64'h1111);
    lo_we = 1'b0; wdata = 32'hAAAA;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5555;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("preload_hi", 64'(hi), 64'hAAAA);
    check("preload_lo", 64'(lo), 64'h5555);

    // Start with cancel in IDLE: nothing accepted, direct write still lands.
    op = T_DIV; a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("cancel_beats_start", 64'(busy), 64'd0);

    // Cancel a DIV on busy cycle 10 with stray start/hi_we pulses earlier.
    op = T_DIV; is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      start = (n == 3);
      a     = (n == 3) ? 32'd5 : 32'd100;
      hi_we = (n == 5);
      wdata = 32'hDEAD;
      cancel = (n == 10);
      @(posedge clk); #1;
    end
    start = 1'b0; hi_we = 1'b0; cancel = 1'b0;
    check("cancel_to_idle", 64'(busy), 64'd0);
    ndone = 0;
    for (int n = 0; n < W + 4; n++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("cancel_no_done", 64'(ndone), 64'd0);
    check("cancel_hi_kept", 64'(hi), 64'hAAAA);
    check("cancel_lo_kept", 64'(lo), 64'h5555);
    check("cancel_div0_clear", 64'(div0), 64'd0);

    // Asynchronous reset in the middle of a MULT.
    op = T_MULT; is_signed = 1'b0; a = 32'd123; b = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("midop_reset_busy", 64'(busy), 64'd0);
    check("midop_reset_done", 64'(done), 64'd0);
    check("midop_reset_hi", 64'(hi), 64'd0);
    check("midop_reset_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(T_MULT, 1'b0, 32'd6, 32'd7, 1'b0);

    // Randomized traffic with a bias toward edge operands.
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = 32'($urandom_range(0, 3)) - 32'd2;
        default: ;
      endcase
      do_op(ro, rs, ra, rb, ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
